// File: rtl/cfg_chain_master.sv
// ---------------------------------------------------------------------------
// cfg_chain_master
//
// Host-side driver for the serial configuration chain of the stream cipher
// core. A parallel configuration word {a_mux, d_en, taps, seed} is shifted
// LSB-first into the slave over exactly CFG_LEN clocks with cfg_en held high.
// During the same pass the slave's previous contents are captured from its
// serial output, so every pass also gives a readback of the old configuration.
//
// Optional feature (macro CFG_CHAIN_VERIFY_EN):
//   After the first pass and its gap, a second pass re-writes the same word
//   and captures it back. A mismatch sets verify_err, which is held until the
//   next accepted start. rd_data still reports the first-pass capture.
//
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset
//   start       request a configuration pass (sampled only in IDLE)
//   wr_data     configuration word to load, bit 0 shifted first
//   rd_data     slave contents captured during the last completed pass
//   busy        high from the cycle after start is accepted until done
//   done        one-cycle pulse at the end of a pass
//   cfg_en      slave chain enable
//   cfg_sdo     serial data to the slave (slave cfg_i)
//   cfg_sdi     serial data from the slave (slave cfg_o)
//   verify_err  readback mismatch flag (only with CFG_CHAIN_VERIFY_EN)
// ---------------------------------------------------------------------------
module cfg_chain_master #(
  parameter int M          = 32,
  parameter int CFG_LEN    = 2*M+2,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CFG_LEN-1:0] wr_data,
  output logic [CFG_LEN-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic               cfg_en,
  output logic               cfg_sdo,
  input  logic               cfg_sdi
`ifdef CFG_CHAIN_VERIFY_EN
  ,
  output logic               verify_err
`endif
);

  // The counter is shared between the shift phase and the gap phase, so
  // GAP_CYCLES is expected to be no larger than CFG_LEN.
  localparam int CW = $clog2(CFG_LEN+1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CFG_LEN-1);
  localparam logic [CW-1:0] LAST_GAP = CW'(GAP_CYCLES-1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q,   state_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic [CFG_LEN-1:0]   tx_sr_q,   tx_sr_d;
  logic [CFG_LEN-1:0]   rx_sr_q,   rx_sr_d;
  logic [CFG_LEN-1:0]   rd_data_q, rd_data_d;
  logic                 cfg_en_q,  cfg_en_d;
  logic                 cfg_sdo_q, cfg_sdo_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
`ifdef CFG_CHAIN_VERIFY_EN
  logic                 second_q,     second_d;
  logic [CFG_LEN-1:0]   rx_first_q,   rx_first_d;
  logic                 verify_err_q, verify_err_d;
`endif

  // Next-state and next-output logic.
  // tx_sr rotates rather than shifting in zeros: after CFG_LEN shifts it holds
  // the latched word again, which the verify pass re-sends and compares to.
  // cfg_sdo is registered, so each SHIFT edge loads the bit that the slave
  // will sample on the following edge (tx_sr_q[1] before the rotation).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rd_data_d = rd_data_q;
    cfg_en_d  = cfg_en_q;
    cfg_sdo_d = cfg_sdo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef CFG_CHAIN_VERIFY_EN
    second_d     = second_q;
    rx_first_d   = rx_first_q;
    verify_err_d = verify_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          tx_sr_d   = wr_data;
          cnt_d     = '0;
          cfg_en_d  = 1'b1;
          cfg_sdo_d = wr_data[0];
          busy_d    = 1'b1;
`ifdef CFG_CHAIN_VERIFY_EN
          second_d     = 1'b0;
          verify_err_d = 1'b0;
`endif
        end
      end

      SHIFT: begin
        tx_sr_d   = {tx_sr_q[0], tx_sr_q[CFG_LEN-1:1]};
        rx_sr_d   = {cfg_sdi, rx_sr_q[CFG_LEN-1:1]};
        cnt_d     = cnt_q + CNT_ONE;
        cfg_sdo_d = tx_sr_q[1];
        if (cnt_q == LAST_BIT) begin
          state_d   = GAP;
          cnt_d     = '0;
          cfg_en_d  = 1'b0;
          cfg_sdo_d = 1'b0;
        end
      end

      GAP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_GAP) begin
          cnt_d   = '0;
          state_d = DONE;
`ifdef CFG_CHAIN_VERIFY_EN
          if (!second_q) begin
            state_d    = SHIFT;
            second_d   = 1'b1;
            rx_first_d = rx_sr_q;
            cfg_en_d   = 1'b1;
            cfg_sdo_d  = tx_sr_q[0];
          end
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef CFG_CHAIN_VERIFY_EN
        rd_data_d    = rx_first_q;
        verify_err_d = (rx_sr_q != tx_sr_q);
`else
        rd_data_d = rx_sr_q;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Every output is a flop cleared by the
  // asynchronous reset, so a reset mid-pass drops cfg_en immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rd_data_q <= '0;
      cfg_en_q  <= 1'b0;
      cfg_sdo_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CFG_CHAIN_VERIFY_EN
      second_q     <= 1'b0;
      rx_first_q   <= '0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rd_data_q <= rd_data_d;
      cfg_en_q  <= cfg_en_d;
      cfg_sdo_q <= cfg_sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CFG_CHAIN_VERIFY_EN
      second_q     <= second_d;
      rx_first_q   <= rx_first_d;
      verify_err_q <= verify_err_d;
`endif
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_en  = cfg_en_q;
  assign cfg_sdo = cfg_sdo_q;
`ifdef CFG_CHAIN_VERIFY_EN
  assign verify_err = verify_err_q;
`endif

endmodule

// File: doc/cfg_chain_master.md
Name: cfg_chain_master

Overview:
- Host-side driver for the serial configuration chain of the stream cipher core, i.e. the cfg_en / cfg_i / cfg_o interface.
- Accepts a parallel configuration word {a_mux, d_en, taps[M-1:0], seed[M-1:0]} and shifts it LSB-first into the slave over exactly CFG_LEN clocks.
- During the same pass it captures the slave's previous configuration from the slave's cfg_o, giving a readback.
- Sits between the control/register block and the cipher core.

Parameters:
- M, 32, LFSR width of the slave.
- CFG_LEN, 2*M+2, number of chain bits; this is also the number of cycles cfg_en is held high.
- GAP_CYCLES, 2, idle cycles with cfg_en low after a shift, before done is pulsed. Minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a configuration pass; sampled only in IDLE.
- wr_data  in  CFG_LEN  configuration word to load; bit 0 is shifted first.
- rd_data  out  CFG_LEN  slave contents captured during the last completed pass.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of a pass.
- cfg_en  out  1  drives the slave cfg_en.
- cfg_sdo  out  1  drives the slave cfg_i.
- cfg_sdi  in  1  driven by the slave cfg_o.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; cfg_en=0, cfg_sdo=0, busy=0, done=0, rd_data=0; shift and capture registers cleared; bit counter=0.
- FSM states are IDLE, SHIFT, GAP, DONE.
- IDLE:
  - On start=1, latch wr_data into the tx shift register (tx_sr), clear the counter, go to SHIFT.
  - busy rises on the next cycle.
- SHIFT:
  - cfg_en=1 and cfg_sdo=tx_sr[0], both registered outputs.
  - Each cycle: tx_sr shifts right by one; the capture register (rx_sr) shifts right with cfg_sdi entering at bit CFG_LEN-1; the counter increments.
  - cfg_sdi is sampled on the same clock edge that the slave uses to shift cfg_sdo in.
  - After exactly CFG_LEN cycles with cfg_en=1, move to GAP with cfg_en=0 on that edge.
  - cfg_en is never high for more or fewer than CFG_LEN consecutive cycles. The slave load pulse depends on this count.
- GAP: cfg_en=0, cfg_sdo=0 for GAP_CYCLES cycles, then go to DONE.
- DONE:
  - rd_data <= rx_sr and done=1, both for one cycle; busy drops in the same cycle.
  - Return to IDLE.
  - A start present in the DONE cycle is ignored; it must be re-asserted in IDLE.
- start while busy is ignored, with no queuing.
- Counter width is $clog2(CFG_LEN+1). There is no wrap inside a pass.
- Resulting bit ordering:
  - After the pass the slave holds wr_data exactly.
  - rd_data[i] equals slave bit i from before the pass.
- Reset mid-SHIFT: cfg_en drops immediately and the slave is left partially shifted. Recovery requires resetting the slave too; the master performs no automatic recovery.
- cfg_sdo is 0 whenever cfg_en=0.

Optional Feature:
- Macro: CFG_CHAIN_VERIFY_EN.
- When defined:
  - After GAP, a second SHIFT pass re-writes the latched word and captures the readback.
  - In DONE, verify_err (extra 1-bit output, reset 0) is set to (captured != latched word) and held until the next start.
  - busy spans both passes. cfg_en is high for two separate bursts of CFG_LEN cycles, separated by GAP_CYCLES low cycles.
  - rd_data reports the first-pass capture.
- When undefined: single pass only; verify_err port absent.

Test Plan:
- Reset, then start with wr_data=66'h3_80000057_0000ACE1 against a slave reset to 66'h0_48000000_00000055 -> cfg_en high exactly 66 cycles; done 66+GAP_CYCLES+1 cycles after the start-accept edge; rd_data=66'h0_48000000_00000055; slave holds 66'h3_80000057_0000ACE1.
- Second start with wr_data=0 -> rd_data=66'h3_80000057_0000ACE1; slave cleared.
- start held high continuously -> passes separated by at least one IDLE cycle; the start pulse issued mid-SHIFT is ignored (no extra cfg_en cycles).
- Assert rst at counter=30 -> cfg_en, busy, cfg_sdo low the same cycle without waiting for a clock edge; rd_data=0; no done pulse.
- wr_data=66'h2_AAAAAAAA_55555555 -> cfg_sdo sequence starts 1,0,1,0…; the last two bits shifted are 0 then 1.
- With CFG_CHAIN_VERIFY_EN and a slave model that forces bit 5 stuck at 0, write 66'h3F -> verify_err=1; with the healthy slave, verify_err=0.
